// File: rtl/tv_runner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tv_runner : vector sequencer/checker; applies stored stimulus, counts misses.
// Optional macro TV_RUNNER_STOP_ON_FAIL_EN ends a run at the first mismatch.
// Revision 1.0
// ============================================================================
module tv_runner #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [IN_W+OUT_W-1:0]    ld_data_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH):0]   num_vec_i,
  output logic [IN_W-1:0]          dut_in_o,
  input  logic [OUT_W-1:0]         dut_out_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [CNT_W-1:0]         err_count_o,
  output logic [$clog2(DEPTH):0]   vec_idx_o,
  output logic [$clog2(DEPTH)-1:0] fail_idx_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int VW = IN_W + OUT_W;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [AW:0]       n_q, n_d;
  logic [OUT_W-1:0]  exp_q, exp_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [AW:0]       vidx_q, vidx_d;
  logic [AW-1:0]     fidx_q, fidx_d;
  logic [VW-1:0]     mem_q [DEPTH];

  logic              busy;
  logic              mismatch;
  logic [AW:0]       n_clamp;
  logic [AW:0]       next_idx;
  logic [VW-1:0]     vec_first;
  logic [VW-1:0]     vec_next;

  assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign n_clamp   = (num_vec_i > DEPTH_C) ? DEPTH_C : num_vec_i;
  assign next_idx  = vidx_q + (AW+1)'(1);
  assign vec_first = mem_q[0];
  assign vec_next  = mem_q[next_idx[AW-1:0]];
  // Case-inequality so that X/Z on the DUT response counts as a failure.
  assign mismatch  = (dut_out_i !== exp_q);

  always_ff @(posedge clk_i) begin
    if (ld_en_i && !busy && ({1'b0, ld_addr_i} < DEPTH_C)) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      exp_q    <= '0;
      dut_in_q <= '0;
      err_q    <= '0;
      vidx_q   <= '0;
      fidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      exp_q    <= exp_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      vidx_q   <= vidx_d;
      fidx_q   <= fidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    exp_d    = exp_q;
    dut_in_d = dut_in_q;
    err_d    = err_q;
    vidx_d   = vidx_q;
    fidx_d   = fidx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          n_d    = n_clamp;
          err_d  = '0;
          fidx_d = '0;
          vidx_d = '0;
          if (n_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            dut_in_d = vec_first[VW-1 -: IN_W];
            exp_d    = vec_first[OUT_W-1:0];
            cnt_d    = SW'(SETTLE - 1);
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != {CNT_W{1'b1}}) begin
            err_d = err_q + CNT_W'(1);
          end
          if (err_q == '0) begin
            fidx_d = vidx_q[AW-1:0];
          end
        end
`ifdef TV_RUNNER_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = S_DONE;
        end else
`endif
        begin
          vidx_d = next_idx;
          if (next_idx < n_q) begin
            dut_in_d = vec_next[VW-1 -: IN_W];
            exp_d    = vec_next[OUT_W-1:0];
            cnt_d    = SW'(SETTLE - 1);
            state_d  = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_in_o    = dut_in_q;
  assign busy_o      = busy;
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = (state_q == S_DONE) && (err_q == '0);
  assign err_count_o = err_q;
  assign vec_idx_o   = vidx_q;
  assign fail_idx_o  = fidx_q;

endmodule
`default_nettype wire

// File: tb/tb_tv_runner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_tv_runner : checks tv_runner against a cycle-timeline reference model.
// Revision 1.0
// ============================================================================
module tb_tv_runner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ld_en_a, ld_en_b, start_a, start_b, use_reg, sel;
  logic [3:0] ld_addr;
  logic [4:0] ld_data, num_a, num_b;
  logic [3:0] din_a, din_b, pa0, pa1, pb0, pb1;
  logic       dout_a, dout_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, err_b;
  logic [4:0] vidx_a, vidx_b;
  logic [3:0] fidx_a, fidx_b;

  // Reference DUTs: AND4, optionally behind a 2-stage register delay.
  always @(posedge clk) begin
    pa0 <= din_a; pa1 <= pa0;
    pb0 <= din_b; pb1 <= pb0;
  end
  assign dout_a = use_reg ? &pa1 : &din_a;
  assign dout_b = &pb1;

  tv_runner #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(1), .CNT_W(16)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .ld_en_i(ld_en_a), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .start_i(start_a), .num_vec_i(num_a), .dut_in_o(din_a),
    .dut_out_i(dout_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(err_a), .vec_idx_o(vidx_a), .fail_idx_o(fidx_a));

  tv_runner #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(3), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .ld_en_i(ld_en_b), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .start_i(start_b), .num_vec_i(num_b), .dut_in_o(din_b),
    .dut_out_i(dout_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(err_b), .vec_idx_o(vidx_b), .fail_idx_o(fidx_b));

  logic        m_busy, m_done, m_pass;
  logic [15:0] m_err;
  logic [4:0]  m_vidx;
  logic [3:0]  m_fidx, m_din;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_pass = sel ? pass_b : pass_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_vidx = sel ? vidx_b : vidx_a;
  assign m_fidx = sel ? fidx_b : fidx_a;
  assign m_din  = sel ? din_b  : din_a;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [4:0] mem_m [16];
  logic [3:0] last_a = 4'd0;
  logic [3:0] last_b = 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int addr, input logic [4:0] data);
    @(posedge clk); #1;
    ld_en_a = 1'b1; ld_en_b = 1'b1; ld_addr = addr[3:0]; ld_data = data;
    @(posedge clk); #1;
    ld_en_a = 1'b0; ld_en_b = 1'b0;
    mem_m[addr] = data;
  endtask

  // Cycle c=0 is the cycle after the start edge; vector k occupies cycles
  // [k*(s+1), k*(s+1)+s] and is judged in its last cycle. A DUT of latency d
  // answers in cycle c with AND4 of whatever was applied in cycle c-d.
  task automatic model(input int n_req, input int s, input int d, input logic [3:0] prev,
                       output int e_err, output int e_fail, output int e_vidx,
                       output int e_cyc, output logic [3:0] e_last);
    int n;
    n = (n_req > 16) ? 16 : n_req;
    e_err = 0; e_fail = 0; e_vidx = n; e_cyc = n * (s + 1); e_last = prev;
    for (int k = 0; k < n; k++) begin
      int c, src;
      logic [3:0] seen;
      c    = k * (s + 1) + s;
      src  = c - d;
      seen = (src < 0) ? prev : mem_m[src / (s + 1)][4:1];
      e_last = mem_m[k][4:1];
      if ((&seen) != mem_m[k][0]) begin
        if (e_err == 0) e_fail = k;
        e_err++;
`ifdef TV_RUNNER_STOP_ON_FAIL_EN
        e_vidx = k;
        e_cyc  = (k + 1) * (s + 1);
        break;
`endif
      end
    end
  endtask

  task automatic run(input bit which, input int n, input bit disturb, input string tag);
    int e_err, e_fail, e_vidx, e_cyc, cyc, bcnt;
    logic [3:0] e_last, prev;
    prev = which ? last_b : last_a;
    model(n, which ? 3 : 1, (which || use_reg) ? 2 : 0, prev, e_err, e_fail, e_vidx, e_cyc, e_last);
    sel = which;
    @(posedge clk); #1;
    if (which) begin start_b = 1'b1; num_b = 5'(n); end
    else       begin start_a = 1'b1; num_a = 5'(n); end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    cyc = 0; bcnt = 0;
    while (!m_done && cyc < 400) begin
      if (m_busy) bcnt++;
      if (disturb && cyc == 3) begin
        ld_en_a = 1'b1; ld_addr = 4'd2; ld_data = ~mem_m[2];
        start_a = 1'b1; num_a = 5'd1;
      end
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 4) begin ld_en_a = 1'b0; start_a = 1'b0; end
    end
    check({tag, ".cycles"},   cyc,    e_cyc);
    check({tag, ".busy_cyc"}, bcnt,   e_cyc);
    check({tag, ".done"},     m_done, 1);
    check({tag, ".pass"},     m_pass, (e_err == 0) ? 1 : 0);
    check({tag, ".err"},      m_err,  e_err);
    check({tag, ".fail_idx"}, m_fidx, e_fail);
    check({tag, ".vec_idx"},  m_vidx, e_vidx);
    check({tag, ".dut_in"},   m_din,  e_last);
    if (which) last_b = e_last; else last_a = e_last;
  endtask

  task automatic reset_checks(input bit which, input string tag);
    sel = which; #0;
    check({tag, ".dut_in"},   m_din,  0);
    check({tag, ".busy"},     m_busy, 0);
    check({tag, ".done"},     m_done, 0);
    check({tag, ".pass"},     m_pass, 0);
    check({tag, ".err"},      m_err,  0);
    check({tag, ".vec_idx"},  m_vidx, 0);
    check({tag, ".fail_idx"}, m_fidx, 0);
  endtask

  initial begin
    reset = 1'b1; ld_en_a = 1'b0; ld_en_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ld_addr = '0; ld_data = '0; num_a = '0; num_b = '0; use_reg = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks(0, "rst_a");
    reset_checks(1, "rst_b");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) load(i, {4'(i), &(4'(i))});
    run(0, 16, 0, "and4_all");
    load(3, mem_m[3] ^ 5'd1);
    load(9, mem_m[9] ^ 5'd1);
    run(0, 16, 0, "and4_bad");
    run(0, 0, 0, "num_zero");
    load(3, mem_m[3] ^ 5'd1);
    load(9, mem_m[9] ^ 5'd1);
    run(0, 20, 0, "clamp20");

    // Alternating patterns make a too-short settle visibly sample stale data.
    load(0, 5'b1111_1); load(1, 5'b0000_0); load(2, 5'b1111_1); load(3, 5'b0000_0);
    run(1, 4, 0, "settle3_reg");
    use_reg = 1'b1;
    run(0, 4, 0, "settle1_reg");
    use_reg = 1'b0;

    load(3, 5'b0000_1);
    sel = 1'b0;
    @(posedge clk); #1; start_a = 1'b1; num_a = 5'd16;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    reset_checks(0, "midrun_a");
    reset_checks(1, "midrun_b");
    @(posedge clk); #1; reset = 1'b0;
    last_a = 4'd0; last_b = 4'd0;
    run(0, 4, 0, "after_reset");

    load(3, 5'b0000_0);
    run(0, 16, 1, "busy_disturb");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] vin;
        vin = 4'($urandom_range(0, 15));
        load(i, {vin, (&vin) ^ ($urandom_range(0, 3) == 0)});
      end
      run(0, $urandom_range(0, 20), 0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tv_runner.md
Name: tv_runner

Overview:
- Synthesizable, parametrised test-vector sequencer/checker that replaces ad-hoc bench loops.
- Holds DEPTH packed vectors {inputs, expected} in an internal memory and applies the input field to a DUT.
- Samples the DUT output after a programmable settle time, counts mismatches and reports pass/fail.
- Sits beside any combinational or registered DUT in chapter exercises and on-board self-test.

Parameters:
- IN_W, 4, DUT input width (input field = MSBs of a vector).
- OUT_W, 1, DUT output width (expected field = LSBs of a vector).
- DEPTH, 16, vector memory depth; AW = $clog2(DEPTH) (localparam).
- SETTLE, 1, cycles between applying a vector and sampling dut_out; legal range >= 1.
- CNT_W, 16, err_count width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ld_en  in  1  vector memory write strobe.
- ld_addr  in  AW  write address.
- ld_data  in  IN_W+OUT_W  packed vector {inputs, expected}.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- num_vec  in  AW+1  number of vectors to run; sampled with start.
- dut_in  out  IN_W  registered stimulus to the DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  high in SETTLE/CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 if err_count == 0.
- err_count  out  CNT_W  mismatch count; saturates at all-ones.
- vec_idx  out  AW+1  index of the vector currently applied / number completed at DONE.
- fail_idx  out  AW  index of the first failing vector; 0 if none.

Behaviour:
- Reset: FSM = IDLE; dut_in, busy, done, pass, err_count, vec_idx, fail_idx all 0. Memory contents are not reset.
- Load:
  - ld_en writes ld_data to mem[ld_addr] at the clock edge.
  - Ignored while busy.
  - ld_addr >= DEPTH is ignored.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1:
  - Latch N = min(num_vec, DEPTH).
  - Clear err_count, fail_idx and vec_idx.
  - If N == 0: go to DONE with pass=1.
  - Else: load dut_in and the internal exp register from mem[0], set settle counter to SETTLE-1, go to SETTLE.
- SETTLE: decrement the counter; at 0, go to CHECK.
- CHECK (exactly one cycle):
  - Compare dut_out against exp. Mismatch includes X/Z in simulation (case-inequality).
  - On mismatch: err_count += 1 (saturating). If it is the first error, fail_idx = vec_idx.
  - vec_idx += 1.
  - If vec_idx+1 < N: load the next vector into dut_in/exp and go to SETTLE. Else go to DONE.
- DONE: done=1, pass=(err_count==0). Outputs hold until a new start or reset.
- Timing: each vector costs SETTLE+1 cycles. With SETTLE=1 and N vectors, done rises 2N edges after the start edge.
- start while busy is ignored.
- Reset mid-run returns to IDLE immediately, with all outputs cleared.
- dut_in holds its last applied value in DONE.

Optional Feature:
- Macro: TV_RUNNER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK sends the FSM straight to DONE with pass=0, err_count=1, fail_idx = vec_idx = failing index. Remaining vectors are not applied.
- Undefined: every vector is checked regardless of failures.

Test Plan:
- Load 16 AND4 vectors with correct expected values, SETTLE=1, start with num_vec=16:
  - busy for 32 cycles, then done=1, pass=1, err_count=0, vec_idx=16.
- Same load with the expected bits of vectors 3 and 9 inverted:
  - done, pass=0, err_count=2, fail_idx=3.
  - With TV_RUNNER_STOP_ON_FAIL_EN: done after 8 cycles, err_count=1, vec_idx=3.
- start with num_vec=0:
  - done=1 on the next cycle, pass=1, err_count=0, busy never high.
- num_vec=20 with DEPTH=16:
  - clamps to 16 vectors, done after 32 cycles.
- SETTLE=3, 4 vectors, DUT with a 2-cycle register delay:
  - all pass, done 16 cycles after start.
  - Re-run with SETTLE=1 reports mismatches.
- Assert reset at the 5th cycle of a run, then pulse start with num_vec=4:
  - outputs 0 during reset.
  - The new run completes normally with err_count counted from 0.
- ld_en and start pulsed while busy:
  - memory and run unaffected, verified by a clean pass.
